multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/mips_pkg.sv | 98 +++++++++
 rtl/alu_decoder.sv | 37 +++
 rtl/multicycle_controller.sv | 103 ++++++++++
 tb/tb_multicycle_controller.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared types and constants for the multicycle MIPS control
//               path: FSM states, opcodes, ALU op classes, ALU control codes
//               and the per-state Moore control word.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Moore part of the control word; FETCH ir_write/pc_write and illegal_op
  // are gated outside because they depend on live inputs.
  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

  // Per-state control word; anything not driven by a state stays 0.
  function automatic ctrl_t moore_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:    c.alu_src_b = 2'b01;
      S_DECODE:   c.alu_src_b = 2'b11;
      S_MEMADR:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEMRD:    c.iord = 1'b1;
      S_MEMWB:    begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
      S_MEMWR:    begin c.iord = 1'b1; c.mem_write = 1'b1; end
      S_EXECUTE:  begin c.alu_src_a = 1'b1; c.alu_op = ALUOP_FUNCT; end
      S_ALUWB:    begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
      S_BRANCH:   begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALUOP_SUB;
        c.pc_src    = 2'b01;
        c.branch    = 1'b1;
      end
      S_ADDIEXEC: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_ADDIWB:   c.reg_write = 1'b1;
      S_JUMP:     begin c.pc_src = 2'b10; c.pc_write = 1'b1; end
      default:    c.alu_src_b = 2'b01;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : alu_decoder
// Description : Maps the FSM ALU op class and the R-type funct field onto
//               the 3-bit ALU control code.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control
);

  // Fixed add/subtract for address and branch work, funct-driven otherwise.
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Multicycle MIPS control FSM (lw, sw, R-type, beq, addi, j).
//               Control word is registered alongside the state; only the
//               FETCH handshake strobes and illegal_op follow live inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic [2:0] alu_control,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl_q;
  logic   fetch_go;
  logic   pc_write;

  // Next-state selection; unknown encodings fall back to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:    state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWR:    state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_ADDIEXEC: state_d = S_ADDIWB;
      S_ADDIWB:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // State and control word registered together so the outputs are glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= moore_ctrl(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= moore_ctrl(state_d);
    end
  end

  // Input-gated strobes are also masked by reset so nothing fires while held.
  assign fetch_go   = (state_q == S_FETCH) && mem_ready && !reset;
  assign illegal_op = (state_q == S_DECODE) && !is_legal_op(op) && !reset;
  assign pc_write   = ctrl_q.pc_write | fetch_go;
  assign pc_en      = pc_write | (ctrl_q.branch & zero);
  assign ir_write   = fetch_go;

  assign iord       = ctrl_q.iord;
  assign mem_write  = ctrl_q.mem_write;
  assign reg_dst    = ctrl_q.reg_dst;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign reg_write  = ctrl_q.reg_write;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign pc_src     = ctrl_q.pc_src;
  assign state_dbg  = state_q;

  alu_decoder u_alu_decoder (
    .alu_op      (ctrl_q.alu_op),
    .funct       (funct),
    .alu_control (alu_control)
  );

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Directed scoreboard bench for multicycle_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;
  import mips_pkg::*;

  localparam logic [5:0] I_R   = 6'b000000;
  localparam logic [5:0] I_LW  = 6'b100011;
  localparam logic [5:0] I_SW  = 6'b101011;
  localparam logic [5:0] I_BEQ = 6'b000100;
  localparam logic [5:0] I_ADD = 6'b001000;
  localparam logic [5:0] I_J   = 6'b000010;
  localparam logic [5:0] I_BAD = 6'b111111;

  typedef struct packed {
    logic [3:0] st;
    logic       iord;
    logic       memw;
    logic       irw;
    logic       regdst;
    logic       m2r;
    logic       regw;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] pcsrc;
    logic       pcen;
    logic [2:0] aluctl;
    logic       ill;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, pc_en, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;
  logic [3:0] state_dbg;

  exp_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad   = 0;
  event  chk_ev;
  exp_t  m_exp, m_act;
  string m_nm;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .funct       (funct),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .iord        (iord),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .reg_write   (reg_write),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .pc_src      (pc_src),
    .pc_en       (pc_en),
    .alu_control (alu_control),
    .illegal_op  (illegal_op),
    .state_dbg   (state_dbg)
  );

  // Monitor: compare the DUT against the oldest pending expectation.
  initial begin
    forever begin
      @(negedge clk or chk_ev);
      if (exp_q.size() > 0) begin
        m_exp = exp_q.pop_front();
        m_nm  = name_q.pop_front();
        m_act = {state_dbg, iord, mem_write, ir_write, reg_dst, mem_to_reg,
                 reg_write, alu_src_a, alu_src_b, pc_src, pc_en, alu_control,
                 illegal_op};
        total++;
        if (m_act !== m_exp) begin
          bad++;
          $display("FAIL %s: got %h want %h", m_nm, m_act, m_exp);
        end
      end
    end
  end

  function automatic exp_t mk(input state_t s);
    exp_t e;
    e = '0;
    e.st = s;
    e.aluctl = 3'b010;
    return e;
  endfunction

  function automatic exp_t e_fetch(input logic go);
    exp_t e;
    e = mk(S_FETCH);
    e.srcb = 2'b01;
    e.irw  = go;
    e.pcen = go;
    return e;
  endfunction

  function automatic exp_t e_decode(input logic ill);
    exp_t e;
    e = mk(S_DECODE);
    e.srcb = 2'b11;
    e.ill  = ill;
    return e;
  endfunction

  task automatic step(input string nm, input logic [5:0] o, input logic [5:0] f,
                      input logic z, input logic r, input exp_t e);
    op = o; funct = f; zero = z; mem_ready = r;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t x;
    reset = 1'b1; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;

    // Held in reset: FETCH values, no strobes even when memory is ready.
    step("rst_idle",  I_LW, 6'd0, 1'b0, 1'b0, e_fetch(1'b0));
    step("rst_ready", I_LW, 6'd0, 1'b1, 1'b1, e_fetch(1'b0));
    reset = 1'b0;
    step("fetch_hold", I_LW, 6'd0, 1'b0, 1'b0, e_fetch(1'b0));

    // lw: 5 cycles
    step("lw_fetch",  I_LW, 6'd0, 1'b0, 1'b1, e_fetch(1'b1));
    step("lw_decode", I_LW, 6'd0, 1'b0, 1'b1, e_decode(1'b0));
    x = mk(S_MEMADR); x.srca = 1; x.srcb = 2'b10;
    step("lw_memadr", I_LW, 6'd0, 1'b0, 1'b1, x);
    x = mk(S_MEMRD); x.iord = 1;
    step("lw_memrd", I_LW, 6'd0, 1'b0, 1'b1, x);
    x = mk(S_MEMWB); x.m2r = 1; x.regw = 1;
    step("lw_memwb", I_LW, 6'd0, 1'b0, 1'b1, x);

    // sw with three wait cycles in MEMWR
    step("sw_fetch",  I_SW, 6'd0, 1'b0, 1'b1, e_fetch(1'b1));
    step("sw_decode", I_SW, 6'd0, 1'b0, 1'b1, e_decode(1'b0));
    x = mk(S_MEMADR); x.srca = 1; x.srcb = 2'b10;
    step("sw_memadr", I_SW, 6'd0, 1'b0, 1'b1, x);
    x = mk(S_MEMWR); x.iord = 1; x.memw = 1;
    step("sw_memwr_w1", I_SW, 6'd0, 1'b0, 1'b0, x);
    step("sw_memwr_w2", I_SW, 6'd0, 1'b0, 1'b0, x);
    step("sw_memwr_w3", I_SW, 6'd0, 1'b0, 1'b0, x);
    step("sw_memwr_go", I_SW, 6'd0, 1'b0, 1'b1, x);

    // beq taken and not taken
    step("beq1_fetch",  I_BEQ, 6'd0, 1'b1, 1'b1, e_fetch(1'b1));
    step("beq1_decode", I_BEQ, 6'd0, 1'b1, 1'b1, e_decode(1'b0));
    x = mk(S_BRANCH); x.srca = 1; x.pcsrc = 2'b01; x.aluctl = 3'b110; x.pcen = 1;
    step("beq1_branch_z1", I_BEQ, 6'd0, 1'b1, 1'b1, x);
    step("beq0_fetch",  I_BEQ, 6'd0, 1'b0, 1'b1, e_fetch(1'b1));
    step("beq0_decode", I_BEQ, 6'd0, 1'b0, 1'b1, e_decode(1'b0));
    x.pcen = 0;
    step("beq0_branch_z0", I_BEQ, 6'd0, 1'b0, 1'b1, x);

    // R-type slt, then R-type and
    step("slt_fetch",  I_R, 6'b101010, 1'b0, 1'b1, e_fetch(1'b1));
    step("slt_decode", I_R, 6'b101010, 1'b0, 1'b1, e_decode(1'b0));
    x = mk(S_EXECUTE); x.srca = 1; x.aluctl = 3'b111;
    step("slt_exec", I_R, 6'b101010, 1'b0, 1'b1, x);
    x = mk(S_ALUWB); x.regdst = 1; x.regw = 1;
    step("slt_aluwb", I_R, 6'b101010, 1'b0, 1'b1, x);
    step("and_fetch",  I_R, 6'b100100, 1'b0, 1'b1, e_fetch(1'b1));
    step("and_decode", I_R, 6'b100100, 1'b0, 1'b1, e_decode(1'b0));
    x = mk(S_EXECUTE); x.srca = 1; x.aluctl = 3'b000;
    step("and_exec", I_R, 6'b100100, 1'b0, 1'b1, x);
    x = mk(S_ALUWB); x.regdst = 1; x.regw = 1;
    step("and_aluwb", I_R, 6'b100100, 1'b0, 1'b1, x);

    // Illegal opcode: one-cycle pulse, straight back to FETCH
    step("bad_fetch",  I_BAD, 6'd0, 1'b0, 1'b1, e_fetch(1'b1));
    step("bad_decode", I_BAD, 6'd0, 1'b0, 1'b1, e_decode(1'b1));
    step("bad_refetch", I_BAD, 6'd0, 1'b0, 1'b0, e_fetch(1'b0));

    // addi: 4 cycles
    step("addi_fetch",  I_ADD, 6'd0, 1'b0, 1'b1, e_fetch(1'b1));
    step("addi_decode", I_ADD, 6'd0, 1'b0, 1'b1, e_decode(1'b0));
    x = mk(S_ADDIEXEC); x.srca = 1; x.srcb = 2'b10;
    step("addi_exec", I_ADD, 6'd0, 1'b0, 1'b1, x);
    x = mk(S_ADDIWB); x.regw = 1;
    step("addi_wb", I_ADD, 6'd0, 1'b0, 1'b1, x);

    // j: 3 cycles
    step("j_fetch",  I_J, 6'd0, 1'b0, 1'b1, e_fetch(1'b1));
    step("j_decode", I_J, 6'd0, 1'b0, 1'b1, e_decode(1'b0));
    x = mk(S_JUMP); x.pcsrc = 2'b10; x.pcen = 1;
    step("j_jump", I_J, 6'd0, 1'b0, 1'b1, x);

    // Asynchronous reset in the middle of a stalled store
    step("sw2_fetch",  I_SW, 6'd0, 1'b0, 1'b1, e_fetch(1'b1));
    step("sw2_decode", I_SW, 6'd0, 1'b0, 1'b1, e_decode(1'b0));
    x = mk(S_MEMADR); x.srca = 1; x.srcb = 2'b10;
    step("sw2_memadr", I_SW, 6'd0, 1'b0, 1'b1, x);
    x = mk(S_MEMWR); x.iord = 1; x.memw = 1;
    step("sw2_memwr", I_SW, 6'd0, 1'b0, 1'b0, x);
    exp_q.push_back(x);
    name_q.push_back("sw2_memwr_pre_rst");
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    exp_q.push_back(e_fetch(1'b0));
    name_q.push_back("async_rst_mid_cycle");
    ->chk_ev;
    @(posedge clk); #1;
    step("rst2_hold", I_SW, 6'd0, 1'b0, 1'b1, e_fetch(1'b0));
    reset = 1'b0;
    step("post_rst_fetch",  I_J, 6'd0, 1'b0, 1'b1, e_fetch(1'b1));
    step("post_rst_decode", I_J, 6'd0, 1'b0, 1'b1, e_decode(1'b0));

    repeat (4) @(posedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
